// File: rtl/sd_card_spi_resp.sv
// SPI-mode SD card responder: answers the init, read and write command set.
// The SPI pins are oversampled in the sys_clk domain.
module sd_card_spi_resp #(
    parameter int NCR          = 1,
    parameter int INIT_RETRIES = 2,
    parameter int RD_WAIT      = 4,
    parameter int WR_BUSY      = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sd_clk,
    input  logic        sd_cs,
    input  logic        sd_mosi,
    output logic        sd_miso,
    output logic [31:0] blk_addr,
    output logic [8:0]  rd_idx,
    input  logic [7:0]  rd_data,
    output logic        wr_valid,
    output logic [7:0]  wr_data,
    output logic [8:0]  wr_idx,
    output logic        wr_done,
    output logic        card_ready
);
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_NCR, S_RESP, S_RD_WAIT, S_RD_TOK, S_RD_DATA,
        S_RD_CRC, S_WR_TOK, S_WR_DATA, S_WR_CRC, S_WR_RESP, S_WR_BUSY
    } state_t;

    localparam logic [1:0] P_IDLE = 2'd0, P_RD = 2'd1, P_WR = 2'd2;
    localparam logic [9:0] NCR_LAST = 10'(NCR - 1);
    localparam logic [9:0] RW_LAST  = 10'(RD_WAIT - 1);
    localparam logic [9:0] WB_LAST  = 10'(WR_BUSY - 1);
    localparam logic [7:0] INIT_R   = 8'(INIT_RETRIES);

    logic [1:0] sclk_q, cs_q, mosi_q;
    logic       sclk_prev_q, cs_prev_q;
    logic [2:0] bit_q;
    logic [6:0] sh_q;
    logic       pend_q, miso_q;
    logic [7:0] tx_q, tx_byte, rx_byte;
    logic       rise, fall, cs_fall, cs_rise, byte_done, load;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] arg_q, arg_d, blk_q, blk_d;
    logic [39:0] resp_q, resp_d;
    logic [2:0]  rlen_q, rlen_d;
    logic [1:0]  post_q, post_d;
    logic        idle_q, idle_d, app_q, app_d, ready_q, ready_d;
    logic [7:0]  init_q, init_d, wr_data_q, wr_data_d;
    logic [8:0]  rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
    logic        wr_valid_q, wr_valid_d, wr_done_q, wr_done_d;
    logic [7:0]  r1;

    assign rise      = sclk_q[1] & ~sclk_prev_q & ~cs_q[1];
    assign fall      = ~sclk_q[1] & sclk_prev_q & ~cs_q[1];
    assign cs_fall   = ~cs_q[1] & cs_prev_q;
    assign cs_rise   = cs_q[1] & ~cs_prev_q;
    assign byte_done = rise & (bit_q == 3'd7);
    assign rx_byte   = {sh_q, mosi_q[1]};
    assign load      = fall & pend_q;
    assign r1        = {7'd0, idle_q};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sclk_q      <= 2'b00;
            cs_q        <= 2'b11;
            mosi_q      <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_q       <= 3'd0;
            sh_q        <= 7'd0;
            pend_q      <= 1'b0;
            tx_q        <= 8'hFF;
            miso_q      <= 1'b1;
        end else begin
            sclk_q      <= {sclk_q[0], sd_clk};
            cs_q        <= {cs_q[0], sd_cs};
            mosi_q      <= {mosi_q[0], sd_mosi};
            sclk_prev_q <= sclk_q[1];
            cs_prev_q   <= cs_q[1];
            if (cs_fall) begin
                bit_q <= 3'd0;
            end else if (rise) begin
                bit_q <= bit_q + 3'd1;
                sh_q  <= {sh_q[5:0], mosi_q[1]};
            end
            if (cs_rise) begin
                pend_q <= 1'b0;
                tx_q   <= 8'hFF;
                miso_q <= 1'b1;
            end else if (byte_done) begin
                pend_q <= 1'b1;
            end else if (fall) begin
                // First falling edge after a byte loads the next byte to send
                pend_q <= 1'b0;
                if (pend_q) begin
                    miso_q <= tx_byte[7];
                    tx_q   <= {tx_byte[6:0], 1'b1};
                end else begin
                    miso_q <= tx_q[7];
                    tx_q   <= {tx_q[6:0], 1'b1};
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 10'd0;
            idx_q      <= 6'd0;
            arg_q      <= 32'd0;
            blk_q      <= 32'd0;
            resp_q     <= 40'hFF_FFFF_FFFF;
            rlen_q     <= 3'd1;
            post_q     <= P_IDLE;
            idle_q     <= 1'b1;
            app_q      <= 1'b0;
            ready_q    <= 1'b0;
            init_q     <= 8'd0;
            rd_idx_q   <= 9'd0;
            wr_idx_q   <= 9'd0;
            wr_data_q  <= 8'd0;
            wr_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            arg_q      <= arg_d;
            blk_q      <= blk_d;
            resp_q     <= resp_d;
            rlen_q     <= rlen_d;
            post_q     <= post_d;
            idle_q     <= idle_d;
            app_q      <= app_d;
            ready_q    <= ready_d;
            init_q     <= init_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            wr_done_q  <= wr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        arg_d      = arg_q;
        blk_d      = blk_q;
        resp_d     = resp_q;
        rlen_d     = rlen_q;
        post_d     = post_q;
        idle_d     = idle_q;
        app_d      = app_q;
        ready_d    = ready_q;
        init_d     = init_q;
        rd_idx_d   = rd_idx_q;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        wr_done_d  = 1'b0;
        if (load && state_q == S_RD_DATA) rd_idx_d = rd_idx_q + 9'd1;
        if (cs_rise) begin
            state_d = S_IDLE;
        end else if (byte_done) begin
            cnt_d = cnt_q + 10'd1;
            unique case (state_q)
                S_IDLE: if (rx_byte[7:6] == 2'b01) begin
                    idx_d   = rx_byte[5:0];
                    cnt_d   = 10'd0;
                    state_d = S_CMD;
                end
                S_CMD: if (cnt_q < 10'd4) begin
                    arg_d = {arg_q[23:0], rx_byte};
                end else begin
                    cnt_d   = 10'd0;
                    state_d = (NCR == 0) ? S_RESP : S_NCR;
                    resp_d  = {r1, 32'hFFFF_FFFF};
                    rlen_d  = 3'd1;
                    post_d  = P_IDLE;
                    app_d   = 1'b0;
                    unique case (1'b1)
                        idx_q == 6'd0: begin
                            idle_d  = 1'b1;
                            ready_d = 1'b0;
                            init_d  = 8'd0;
                            resp_d  = {8'h01, 32'hFFFF_FFFF};
                        end
                        idx_q == 6'd8: begin
                            resp_d = {r1, 24'h000001, arg_q[7:0]};
                            rlen_d = 3'd5;
                        end
                        idx_q == 6'd55: app_d = 1'b1;
                        idx_q == 6'd41 && app_q: begin
                            if (init_q < INIT_R) begin
                                init_d = init_q + 8'd1;
                                resp_d = {8'h01, 32'hFFFF_FFFF};
                            end else begin
                                idle_d  = 1'b0;
                                ready_d = 1'b1;
                                resp_d  = {8'h00, 32'hFFFF_FFFF};
                            end
                        end
                        idx_q == 6'd58: begin
                            resp_d = {r1, 32'hC0FF_8000};
                            rlen_d = 3'd5;
                        end
                        idx_q == 6'd17 && ready_q: begin
                            blk_d    = arg_q;
                            rd_idx_d = 9'd0;
                            resp_d   = {8'h00, 32'hFFFF_FFFF};
                            post_d   = P_RD;
                        end
                        idx_q == 6'd24 && ready_q: begin
                            blk_d  = arg_q;
                            resp_d = {8'h00, 32'hFFFF_FFFF};
                            post_d = P_WR;
                        end
                        default: resp_d = {r1 | 8'h04, 32'hFFFF_FFFF};
                    endcase
                end
                S_NCR: if (cnt_q == NCR_LAST) begin
                    cnt_d   = 10'd0;
                    state_d = S_RESP;
                end
                S_RESP: begin
                    resp_d = {resp_q[31:0], 8'hFF};
                    if (cnt_q == {7'd0, rlen_q} - 10'd1) begin
                        cnt_d = 10'd0;
                        if (post_q == P_RD)
                            state_d = (RD_WAIT == 0) ? S_RD_TOK : S_RD_WAIT;
                        else if (post_q == P_WR)
                            state_d = S_WR_TOK;
                        else
                            state_d = S_IDLE;
                    end
                end
                S_RD_WAIT: if (cnt_q == RW_LAST) state_d = S_RD_TOK;
                S_RD_TOK: begin
                    cnt_d   = 10'd0;
                    state_d = S_RD_DATA;
                end
                S_RD_DATA: if (cnt_q == 10'd511) begin
                    cnt_d   = 10'd0;
                    state_d = S_RD_CRC;
                end
                S_RD_CRC: if (cnt_q == 10'd1) state_d = S_IDLE;
                S_WR_TOK: if (rx_byte == 8'hFE) begin
                    cnt_d   = 10'd0;
                    state_d = S_WR_DATA;
                end
                S_WR_DATA: begin
                    wr_valid_d = 1'b1;
                    wr_data_d  = rx_byte;
                    wr_idx_d   = cnt_q[8:0];
                    if (cnt_q == 10'd511) begin
                        cnt_d   = 10'd0;
                        state_d = S_WR_CRC;
                    end
                end
                S_WR_CRC: if (cnt_q == 10'd1) begin
                    wr_done_d = 1'b1;
                    state_d   = S_WR_RESP;
                end
                S_WR_RESP: begin
                    cnt_d   = 10'd0;
                    state_d = (WR_BUSY == 0) ? S_IDLE : S_WR_BUSY;
                end
                S_WR_BUSY: if (cnt_q == WB_LAST) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_byte = 8'hFF;
        unique case (state_q)
            S_RESP:    tx_byte = resp_q[39:32];
            S_RD_TOK:  tx_byte = 8'hFE;
            S_RD_DATA: tx_byte = rd_data;
            S_WR_RESP: tx_byte = 8'h05;
            S_WR_BUSY: tx_byte = 8'h00;
            default:   tx_byte = 8'hFF;
        endcase
    end

    assign sd_miso    = miso_q;
    assign blk_addr   = blk_q;
    assign rd_idx     = rd_idx_q;
    assign wr_valid   = wr_valid_q;
    assign wr_data    = wr_data_q;
    assign wr_idx     = wr_idx_q;
    assign wr_done    = wr_done_q;
    assign card_ready = ready_q;
endmodule

// File: doc/sd_card_spi_resp.md
SD_CARD_SPI_RESP -- requirements
Module: sd_card_spi_resp

Interface
REQ-001 Parameter NCR, default 1: count of 0xFF bytes sent between the command's last byte and the response.
REQ-002 Parameter INIT_RETRIES, default 2: count of ACMD41 answered 0x01 before ACMD41 is answered 0x00.
REQ-003 Parameter RD_WAIT, default 4: count of 0xFF bytes between the CMD17 R1 and the 0xFE token.
REQ-004 Parameter WR_BUSY, default 8: count of 0x00 busy bytes after the write data-response.
REQ-005 sys_clk  in  1  block clock, at least 8x sd_clk frequency.
REQ-006 sys_rst  in  1  asynchronous, active-high reset.
REQ-007 sd_clk  in  1  SPI clock from the host, mode 0.
REQ-008 sd_cs  in  1  chip select, active low.
REQ-009 sd_mosi  in  1  host-to-card serial data, MSB first.
REQ-010 sd_miso  out  1  card-to-host serial data, MSB first.
REQ-011 blk_addr  out  32  sector argument latched from CMD17/CMD24.
REQ-012 rd_idx  out  9  byte index 0..511 of the read byte requested.
REQ-013 rd_data  in  8  byte at blk_addr/rd_idx; valid within 4 sys_clk cycles of rd_idx changing.
REQ-014 wr_valid  out  1  one-cycle strobe: wr_data/wr_idx valid.
REQ-015 wr_data  out  8  received write-block byte.
REQ-016 wr_idx  out  9  index 0..511 of wr_data.
REQ-017 wr_done  out  1  one-cycle pulse after byte 511 and both CRC bytes are received.
REQ-018 card_ready  out  1  high once ACMD41 has returned 0x00.

Function
REQ-019 sd_clk, sd_cs and sd_mosi SHALL each pass a 2-flop synchronizer; sd_clk rising/falling edges SHALL be detected in the sys_clk domain.
REQ-020 sd_mosi SHALL be sampled on sd_clk rising edges; sd_miso SHALL change only on sd_clk falling edges or on sd_cs deassert.
REQ-021 The bit counter SHALL clear on sd_cs falling; every 8 rising edges form one byte.
REQ-022 The next transmit byte SHALL be loaded at the falling edge following a byte's 8th rising edge, so its MSB is stable before the next byte's first rising edge.
REQ-023 States: IDLE, CMD, NCR, RESP, RD_WAIT, RD_TOK, RD_DATA, RD_CRC, WR_TOK, WR_DATA, WR_CRC, WR_RESP, WR_BUSY.
REQ-024 IDLE: transmit 0xFF; a received byte with bits[7:6]=01 SHALL latch the index and enter CMD.
REQ-025 CMD: collect 4 argument bytes plus 1 CRC byte (CRC ignored), then enter NCR; NCR sends NCR bytes of 0xFF, then RESP.
REQ-026 R1 bit0 = idle flag; R1 bit2 = illegal command; all other R1 bits 0.
REQ-027 CMD0: set idle flag, clear card_ready, clear init counter, R1=0x01.
REQ-028 CMD8: R7 = R1, 0x00, 0x00, 0x01, arg[7:0].
REQ-029 CMD55: set app flag, R1; app flag SHALL clear after the next command, whatever it is.
REQ-030 ACMD41 (index 41 with app flag): while init counter < INIT_RETRIES, increment and return 0x01; else clear idle flag, set card_ready, return 0x00.
REQ-031 CMD58: R3 = R1, 0xC0, 0xFF, 0x80, 0x00.
REQ-032 CMD17 while card_ready: latch blk_addr=arg, R1=0x00, RD_WAIT, 0xFE token, 512 data bytes from rd_data at rd_idx 0..511, 2 bytes 0xFF, IDLE.
REQ-033 rd_idx SHALL advance at each data-byte load so the next byte is presented at least one byte time early.
REQ-034 CMD24 while card_ready: latch blk_addr, R1=0x00, WR_TOK sends 0xFF until 0xFE is received; WR_DATA pulses wr_valid per byte, idx 0..511; WR_CRC takes 2 bytes, pulses wr_done; WR_RESP sends 0x05; WR_BUSY sends WR_BUSY bytes of 0x00; then IDLE.
REQ-035 CMD17/CMD24 while not card_ready, or any other index: R1 = 0x04 | idle flag, then IDLE.
REQ-036 Bytes received during RESP and read states SHALL be ignored.
REQ-037 sd_cs rising in any state: return to IDLE, sd_miso=1, no wr_done; idle flag, app flag, init counter, card_ready retained.

Reset
REQ-038 sys_rst SHALL asynchronously set: state IDLE, sd_miso=1, idle flag=1, app flag=0, init counter=0, card_ready=0, blk_addr=0, rd_idx=0, wr_valid=0, wr_data=0, wr_idx=0, wr_done=0.

Verification
REQ-039 CMD0 0x40 00000000 95 -> one 0xFF then 0x01; card_ready=0.
REQ-040 CMD8 arg 0x000001AA -> 0x01 00 00 01 AA.
REQ-041 CMD55+ACMD41 x3 -> 0x01, 0x01, 0x00; card_ready=1 after the third.
REQ-042 CMD17 arg 0x00000010, rd_data=rd_idx[7:0] -> R1 0x00, 4x 0xFF, 0xFE, bytes 00..FF twice, 0xFF 0xFF; blk_addr=0x10.
REQ-043 CMD24 arg 0x20, 0xFE, 512 bytes, 2 CRC -> 512 wr_valid pulses in order, one wr_done, 0x05, 8x 0x00, then 0xFF.
REQ-044 sd_cs raised at read byte 100, then CMD17 reissued -> clean restart from rd_idx 0; card_ready still 1.
